uart_sched: RTL and testbench
=============================

// Module: uart_sched
// PURPOSE
//  Bus master that owns the uart register port. After reset it programs the baud divisor, then
//  polls the line status register (LSR) continuously. It drains received bytes to one consumer and
//  shares the transmitter round-robin between N_REQ byte-stream requesters. It sits between the
//  console clients and the uart, which then has no other bus master.
// PARAMETERS
//  N_REQ    2        number of TX requesters (1..8)
//  DIV_RST  16'd277  divisor programmed after reset (115200 baud)
// PORTS
//  i_clk          in   1        clock
//  i_rst_n        in   1        asynchronous active-low reset
//  i_req_valid    in   N_REQ    requester k has a byte to send; hold until ready
//  i_req_data     in   8*N_REQ  byte of requester k in [8k+7:8k]; stable while valid
//  o_req_ready    out  N_REQ    one-cycle one-hot pulse: byte of k written to THR
//  o_rx_valid     out  1        o_rx_data holds a received byte
//  o_rx_data      out  8        received byte
//  i_rx_ready     in   1        consumer takes byte when o_rx_valid & i_rx_ready
//  i_cfg_start    in   1        pulse: reprogram divisor with i_cfg_div
//  i_cfg_div      in   16       new divisor, sampled when i_cfg_start=1
//  o_cfg_done     out  1        1 = divisor programmed, TX/RX service active
//  o_uart_addr    out  3        uart register address
//  o_uart_stb     out  1        access strobe
//  o_uart_we      out  4        byte write enables; 0 = read
//  o_uart_dat_w   out  32       write data
//  i_uart_ack     in   1        access complete (may be same cycle as stb)
//  i_uart_dat_r   in   32       read data, valid when ack
// BEHAVIOUR
//  Reset: o_uart_stb=0, addr=0, we=0, dat_w=0, o_req_ready=0, o_rx_valid=0, o_rx_data=0,
//   o_cfg_done=0, div_reg=DIV_RST, rr_ptr=0. FSM enters CFG_LCR1.
//  Bus: o_uart_* are registered outputs. There is one access at a time.
//   - stb is held with constant addr/we/dat until a cycle with stb & ack. That cycle is the completion.
//   - stb=0 for exactly one cycle (GAP) after every completion, so uart flags settle before the next access.
//  Configuration sequence (o_cfg_done=0 throughout):
//   CFG_LCR1 addr3 we=1000 dat[31]=1 (set DLAB)
//   -> CFG_DLL addr0 we=0001 dat[7:0]=div[7:0]
//   -> CFG_DLM addr1 we=0010 dat[15:8]=div[15:8]
//   -> CFG_LCR0 addr3 we=1000 dat=0 (clear DLAB)
//   -> POLL, setting o_cfg_done=1.
//   No THR write or RBR read ever occurs while DLAB=1.
//  POLL: read addr5 (we=0). On completion latch dr=dat_r[8] and the=dat_r[14], then decide:
//   - dr & ~o_rx_valid -> RXRD (RX has priority over TX)
//   - else the & |i_req_valid -> TXWR, with grant g = first valid requester at or after rr_ptr (mod N_REQ)
//   - else back to POLL.
//   - A pending cfg request overrides all of the above: -> CFG_LCR1 with o_cfg_done=0.
//  RXRD: read addr0. On completion: o_rx_data=dat_r[7:0], o_rx_valid=1. The read clears DR in the uart.
//   o_rx_valid stays 1 until the cycle after a handshake. While it is 1, further DR=1 results are left in
//   the uart: no read, no loss.
//  TXWR: write addr0 we=0001 dat[7:0]=byte of g. o_req_ready[g]=1 in the completion cycle only.
//   rr_ptr=(g+1) mod N_REQ. The FSM always returns to POLL afterwards: at most one byte per THE observation.
//  i_cfg_start: latches i_cfg_div into div_reg and sets cfg_pend. It never aborts an access in flight;
//   it takes effect at the next POLL decision. A second pulse before then overwrites the divisor.
//  Asynchronous reset mid-access: all outputs return to reset values immediately. The sequence restarts
//   at CFG_LCR1 with DIV_RST.
//  Requester dropping valid before ready: allowed only if it is not the current grant. Any pending TXWR
//   completes using the latched byte.
// TESTING
//  1 Reset release, ack tied to stb -> four writes:
//    (3,1000,0x80000000), (0,0001,0x00000015), (1,0010,0x00000100), (3,1000,0);
//    then o_cfg_done=1 and reads of addr5 repeat every 2 cycles.
//  2 LSR model returns THE=1; req0 and req1 both valid with 0x41/0x42 -> THR writes 0x41 then 0x42 in
//    that order; single-cycle o_req_ready 01 then 10.
//  3 LSR DR=1, RBR=0x5A, i_rx_ready=0 for 20 cycles -> exactly one addr0 read; o_rx_valid=1,
//    o_rx_data=0x5A held; no second read.
//  4 DR=1 and THE=1 with req0 valid simultaneously -> RBR read precedes THR write.
//  5 i_cfg_start with div 0x1234 during a TXWR with ack stalled 5 cycles -> write completes,
//    then (0,0001,0x34) and (1,0010,0x1200) inside the DLAB sequence.
//  6 i_rst_n low while stb high -> stb=0 the same cycle; after release, the CFG sequence repeats with 277.

Source files
------------

// File: rtl/uart_sched_if.sv
// uart_sched_if: uart register port between the scheduler (master) and the uart (slave).
interface uart_sched_if;
    logic [2:0]  addr;
    logic        stb;
    logic [3:0]  we;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;
    modport master(output addr, stb, we, dat_w, input ack, dat_r);
    modport slave(input addr, stb, we, dat_w, output ack, dat_r);
endinterface

// File: rtl/uart_sched.sv
// uart_sched: sole bus master of a uart; programs the divisor, polls LSR, drains RX
// and shares TX round-robin between byte-stream requesters.
module uart_sched #(
    parameter int          N_REQ   = 2,
    parameter logic [15:0] DIV_RST = 16'd277
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic                 o_rx_valid,
    output logic [7:0]           o_rx_data,
    input  logic                 i_rx_ready,
    input  logic                 i_cfg_start,
    input  logic [15:0]          i_cfg_div,
    output logic                 o_cfg_done,
    uart_sched_if.master         uart
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {S_LCR1, S_DLL, S_DLM, S_LCR0, S_POLL, S_RXRD, S_TXWR} state_t;

    state_t        state, state_nxt;
    logic [15:0]   div_reg;
    logic          cfg_pend;
    logic [PW-1:0] rr_ptr, gnt, g;
    logic [7:0]    tx_byte;
    logic [2:0]    addr_d;
    logic [3:0]    we_d;
    logic [31:0]   dat_d;
    logic          done, dr, the, poll_take;
    logic          unused_ok;

    assign done      = uart.stb & uart.ack;
    assign dr        = uart.dat_r[8];
    assign the       = uart.dat_r[14];
    assign poll_take = done & (state == S_POLL);
    assign unused_ok = ^{uart.dat_r[31:15], uart.dat_r[13:9]};

    // first valid requester at or after rr_ptr; scanning downward lets the nearest one win
    always_comb begin
        int idx;
        idx = 0;
        g = rr_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (i_req_valid[idx]) g = PW'(idx);
        end
    end

    always_comb begin
        state_nxt = state;
        if (done) begin
            case (state)
                S_LCR1:  state_nxt = S_DLL;
                S_DLL:   state_nxt = S_DLM;
                S_DLM:   state_nxt = S_LCR0;
                S_POLL:  state_nxt = cfg_pend ? S_LCR1 :
                                     (dr & ~o_rx_valid) ? S_RXRD :
                                     (the & |i_req_valid) ? S_TXWR : S_POLL;
                default: state_nxt = S_POLL;
            endcase
        end
    end

    always_comb begin
        addr_d = 3'd0;
        we_d   = 4'b0000;
        dat_d  = 32'd0;
        case (state)
            S_LCR1: begin addr_d = 3'd3; we_d = 4'b1000; dat_d = 32'h8000_0000; end
            S_DLL:  begin we_d = 4'b0001; dat_d = {24'd0, div_reg[7:0]}; end
            S_DLM:  begin addr_d = 3'd1; we_d = 4'b0010; dat_d = {16'd0, div_reg[15:8], 8'd0}; end
            S_LCR0: begin addr_d = 3'd3; we_d = 4'b1000; end
            S_POLL: addr_d = 3'd5;
            S_TXWR: begin we_d = 4'b0001; dat_d = {24'd0, tx_byte}; end
            default: ;
        endcase
    end

    // every access state spends one cycle with stb low first: that is the post-completion gap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_LCR1;
            uart.stb    <= 1'b0;
            uart.addr   <= 3'd0;
            uart.we     <= 4'b0000;
            uart.dat_w  <= 32'd0;
            o_req_ready <= '0;
            o_rx_valid  <= 1'b0;
            o_rx_data   <= 8'd0;
            o_cfg_done  <= 1'b0;
            div_reg     <= DIV_RST;
            cfg_pend    <= 1'b0;
            rr_ptr      <= '0;
            gnt         <= '0;
            tx_byte     <= 8'd0;
        end else begin
            state       <= state_nxt;
            uart.stb    <= ~done;
            o_req_ready <= '0;
            if (!uart.stb) begin
                uart.addr  <= addr_d;
                uart.we    <= we_d;
                uart.dat_w <= dat_d;
            end
            if (done && state == S_TXWR) begin
                o_req_ready <= N_REQ'(1) << gnt;
                rr_ptr      <= (gnt == PW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
            end
            if (done && state == S_RXRD) begin
                o_rx_valid <= 1'b1;
                o_rx_data  <= uart.dat_r[7:0];
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
            if (done && state == S_LCR0) o_cfg_done <= 1'b1;
            else if (poll_take && cfg_pend) o_cfg_done <= 1'b0;
            if (i_cfg_start) begin
                cfg_pend <= 1'b1;
                div_reg  <= i_cfg_div;
            end else if (poll_take) begin
                cfg_pend <= 1'b0;
            end
            if (poll_take && state_nxt == S_TXWR) begin
                gnt     <= g;
                tx_byte <= i_req_data[8*g +: 8];
            end
        end
    end
endmodule

// File: tb/tb_uart_sched.sv
// tb_uart_sched: directed scoreboard bench; non-poll bus accesses are checked against
// an expected queue, with a small LSR/RBR model answering the reads.
module tb_uart_sched;
    typedef logic [38:0] acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_div = 16'h0000;
    logic        cfg_done;

    logic        lsr_dr = 1'b0, lsr_the = 1'b0, hold_tx = 1'b0;
    logic [7:0]  rbr = 8'h00;
    int          rbr_lim = 0, rbr_reads = 0;
    int          cyc = 0, last_poll = 0, poll_gap = 0;
    int          n_assert = 0, n_fail = 0, rd = 0;
    acc_t        exp_q[$];
    acc_t        obs_q[$];
    logic        dr_eff;

    uart_sched_if bus();

    assign dr_eff      = lsr_dr && (rbr_reads < rbr_lim);
    assign bus.ack     = bus.stb & ~(hold_tx & bus.addr == 3'd0 & bus.we == 4'b0001);
    assign bus.dat_r   = bus.addr == 3'd5 ? {17'd0, lsr_the, 5'd0, dr_eff, 8'd0} :
                         bus.addr == 3'd0 ? {24'd0, rbr} : 32'd0;

    uart_sched #(.N_REQ(2), .DIV_RST(16'd277)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
        .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_rx_ready(rx_ready),
        .i_cfg_start(cfg_start), .i_cfg_div(cfg_div), .o_cfg_done(cfg_done),
        .uart(bus)
    );

    always #5 clk = ~clk;

    // bus monitor: records every completed non-poll access, tracks poll spacing and RBR reads
    always @(negedge clk) begin
        cyc++;
        if (bus.stb && bus.ack) begin
            if (bus.addr == 3'd5 && bus.we == 4'b0000) begin
                poll_gap  = cyc - last_poll;
                last_poll = cyc;
            end else begin
                obs_q.push_back({bus.addr, bus.we, bus.dat_w});
                if (bus.addr == 3'd0 && bus.we == 4'b0000) rbr_reads++;
            end
        end
    end

    task automatic chk(input string tag, input acc_t obs, input acc_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        int need = rd + exp_q.size();
        int t = 0;
        acc_t e;
        while (obs_q.size() < need && t < 300) begin
            @(negedge clk);
            t++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, rd < obs_q.size() ? obs_q[rd] : 'x, e);
            rd++;
        end
    endtask

    task automatic wait_rdy(output logic [1:0] r);
        r = 2'b00;
        for (int t = 0; t < 300 && r == 2'b00; t++) begin
            @(negedge clk);
            r = req_ready;
        end
    endtask

    task automatic push_cfg(input logic [15:0] d);
        exp_q.push_back({3'd3, 4'b1000, 32'h8000_0000});
        exp_q.push_back({3'd0, 4'b0001, 24'd0, d[7:0]});
        exp_q.push_back({3'd1, 4'b0010, 16'd0, d[15:8], 8'd0});
        exp_q.push_back({3'd3, 4'b1000, 32'd0});
    endtask

    initial begin
        logic [1:0] r;
        int base;
        bit seen;
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_stb", acc_t'(bus.stb), 39'd0);
        chk("rst_addr", acc_t'(bus.addr), 39'd0);
        chk("rst_we", acc_t'(bus.we), 39'd0);
        chk("rst_dat", acc_t'(bus.dat_w), 39'd0);
        chk("rst_ready", acc_t'(req_ready), 39'd0);
        chk("rst_rxv", acc_t'(rx_valid), 39'd0);
        chk("rst_rxd", acc_t'(rx_data), 39'd0);
        chk("rst_done", acc_t'(cfg_done), 39'd0);
        // 1: configuration sequence with the reset divisor, then steady LSR polling
        push_cfg(16'd277);
        rst_n = 1'b1;
        sb_check("cfg_seq");
        repeat (10) @(negedge clk);
        chk("cfg_done", acc_t'(cfg_done), 39'd1);
        chk("poll_gap", acc_t'(poll_gap), 39'd2);
        // 2: two requesters, round-robin order 0 then 1
        req_data  = 16'h4241;
        req_valid = 2'b11;
        lsr_the   = 1'b1;
        exp_q.push_back({3'd0, 4'b0001, 32'h41});
        exp_q.push_back({3'd0, 4'b0001, 32'h42});
        wait_rdy(r);
        chk("rdy_first", acc_t'(r), 39'b01);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rdy_pulse1", acc_t'(req_ready), 39'd0);
        wait_rdy(r);
        chk("rdy_second", acc_t'(r), 39'b10);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("rdy_pulse2", acc_t'(req_ready), 39'd0);
        sb_check("thr_order");
        // 3: DR stuck high, consumer stalled: a single RBR read, byte held
        lsr_the = 1'b0;
        rbr     = 8'h5A;
        base    = rbr_reads;
        rbr_lim = 1000;
        lsr_dr  = 1'b1;
        exp_q.push_back({3'd0, 4'b0000, 32'd0});
        repeat (20) @(negedge clk);
        sb_check("rbr_read");
        chk("rx_valid", acc_t'(rx_valid), 39'd1);
        chk("rx_data", acc_t'(rx_data), 39'h5A);
        chk("rbr_count", acc_t'(rbr_reads - base), 39'd1);
        chk("no_extra3", acc_t'(obs_q.size() - rd), 39'd0);
        lsr_dr   = 1'b0;
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rx_taken", acc_t'(rx_valid), 39'd0);
        // 4: RX and TX both ready in the same LSR result: RBR read goes first
        rbr       = 8'h66;
        rbr_lim   = rbr_reads + 1;
        req_data  = 16'h0077;
        lsr_dr    = 1'b1;
        lsr_the   = 1'b1;
        req_valid = 2'b01;
        exp_q.push_back({3'd0, 4'b0000, 32'd0});
        exp_q.push_back({3'd0, 4'b0001, 32'h77});
        wait_rdy(r);
        req_valid = 2'b00;
        chk("rx_first_rdy", acc_t'(r), 39'b01);
        sb_check("rx_before_tx");
        chk("rx_data4", acc_t'(rx_data), 39'h66);
        lsr_dr = 1'b0;
        // 5: reprogram request arrives while a THR write is stalled
        hold_tx   = 1'b1;
        req_data  = 16'h0099;
        req_valid = 2'b01;
        seen      = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = bus.stb && bus.addr == 3'd0 && bus.we == 4'b0001;
        end
        chk("tx_stalled_seen", acc_t'(seen), 39'd1);
        exp_q.push_back({3'd0, 4'b0001, 32'h99});
        push_cfg(16'h1234);
        cfg_div   = 16'h1234;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_stb", acc_t'(bus.stb), 39'd1);
        chk("stall_dat", acc_t'(bus.dat_w), 39'h99);
        chk("stall_done", acc_t'(cfg_done), 39'd1);
        hold_tx = 1'b0;
        wait_rdy(r);
        req_valid = 2'b00;
        chk("stall_rdy", acc_t'(r), 39'b01);
        sb_check("recfg_seq");
        @(negedge clk);
        chk("recfg_done", acc_t'(cfg_done), 39'd1);
        repeat (6) @(negedge clk);
        chk("no_extra5", acc_t'(obs_q.size() - rd), 39'd0);
        // 6: asynchronous reset in the middle of an access
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = bus.stb;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_stb", acc_t'(bus.stb), 39'd0);
        chk("arst_done", acc_t'(cfg_done), 39'd0);
        @(negedge clk);
        push_cfg(16'd277);
        rst_n = 1'b1;
        sb_check("cfg_after_rst");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
